// File: rtl/armleocpu_avl_pkg.sv
// Shared types and constants for the Avalon-MM read arbiter.
package armleocpu_avl_pkg;

    localparam int AVL_ADDR_W = 34;
    localparam int AVL_DATA_W = 32;

    localparam logic [1:0] AVL_RESP_OKAY = 2'b00;
    localparam logic [1:0] AVL_RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/armleocpu_rr_select.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping modulo N.
module armleocpu_rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/armleocpu_avl_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM read master between N requesters.
// Optional macro ARMLEOCPU_AVL_ARB_TIMEOUT_EN adds a forced-error timeout in WAIT_DATA.
module armleocpu_avl_read_arbiter
    import armleocpu_avl_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [N-1:0]            req_read,
    input  logic [N*AVL_ADDR_W-1:0] req_address,
    output logic [N-1:0]            req_waitrequest,
    output logic [N-1:0]            req_readdatavalid,
    output logic [AVL_DATA_W-1:0]   req_readdata,
    output logic [1:0]              req_response,

    output logic [AVL_ADDR_W-1:0]   avl_address,
    output logic                    avl_read,
    input  logic                    avl_waitrequest,
    input  logic                    avl_readdatavalid,
    input  logic [AVL_DATA_W-1:0]   avl_readdata,
    input  logic [1:0]              avl_response
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (N < 1 || N > 8 || TIMEOUT < 1) begin : g_param_check
        $error("armleocpu_avl_read_arbiter: N must be 1..8 and TIMEOUT positive");
    end

    state_t           state, state_nxt;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             timeout_fire;
    logic             deliver;
    logic [IDX_W-1:0] ptr_after_grant;

    armleocpu_rr_select #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (req_read),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

`ifdef ARMLEOCPU_AVL_ARB_TIMEOUT_EN
    localparam int TO_RAW = $clog2(TIMEOUT + 1);
    localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT_DATA, so it starts from zero on every entry.
    always_ff @(posedge clk) begin
        if (!rst_n || state != WAIT_DATA) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_fire = (state == WAIT_DATA) && !avl_readdatavalid
                          && (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign timeout_fire = 1'b0;
`endif

    assign deliver         = (state == WAIT_DATA) && (avl_readdatavalid || timeout_fire);
    assign ptr_after_grant = (int'(grant) == N - 1) ? '0 : grant + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (sel_valid)        state_nxt = ISSUE;
            ISSUE:     if (!avl_waitrequest) state_nxt = WAIT_DATA;
            WAIT_DATA: if (deliver)          state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            avl_address <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sel_valid) begin
                grant       <= sel_idx;
                avl_address <= req_address[int'(sel_idx)*AVL_ADDR_W +: AVL_ADDR_W];
            end
            if (deliver) begin
                rr_ptr <= ptr_after_grant;
            end
        end
    end

    always_comb begin
        avl_read          = (state == ISSUE);
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        if (state == ISSUE) begin
            req_waitrequest[grant] = avl_waitrequest;
        end
        if (deliver) begin
            req_readdatavalid[grant] = 1'b1;
        end
    end

    // Data and response pass straight through; a timeout substitutes an error beat.
    assign req_readdata = timeout_fire ? '0 : avl_readdata;
    assign req_response = timeout_fire ? AVL_RESP_ERR : avl_response;

endmodule

// File: tb/tb_armleocpu_avl_read_arbiter.sv
// Directed bench for armleocpu_avl_read_arbiter: transaction-level model plus literal expectations.
module tb_armleocpu_avl_read_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_read = '0;
    logic [N*34-1:0] req_address = '0;
    logic [N-1:0]    req_waitrequest;
    logic [N-1:0]    req_readdatavalid;
    logic [31:0]     req_readdata;
    logic [1:0]      req_response;
    logic [33:0]     avl_address;
    logic            avl_read;
    logic            avl_waitrequest = 1'b1;
    logic            avl_readdatavalid = 1'b0;
    logic [31:0]     avl_readdata = '0;
    logic [1:0]      avl_response = '0;

    always #5 clk = ~clk;

    armleocpu_avl_read_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_read          (req_read),
        .req_address       (req_address),
        .req_waitrequest   (req_waitrequest),
        .req_readdatavalid (req_readdatavalid),
        .req_readdata      (req_readdata),
        .req_response      (req_response),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_waitrequest   (avl_waitrequest),
        .avl_readdatavalid (avl_readdatavalid),
        .avl_readdata      (avl_readdata),
        .avl_response      (avl_response)
    );

    int checks = 0;
    int errors = 0;

    // transaction model
    bit          m_issue = 0, m_wait = 0;
    int          m_owner = 0, m_ptr = 0, m_cnt = 0;
    logic [33:0] m_addr = '0;

    // bus slave
    int          bus_wait = 0, bus_lat = 1;
    bit          bus_mute = 0, inject_rdv = 0;
    bit          b_pend = 0, acc_seen = 0, rst_seen = 0;
    int          b_lat = 0, b_wcnt = 0;
    logic [33:0] b_addr = '0, acc_addr = '0;

    // requesters and log
    int          issued[N], accepted[N];
    logic [33:0] raddr[N];
    int          log_n = 0, rd_cnt = 0;
    int          log_owner[64], log_lat[64];
    logic [31:0] log_data[64];
    logic [1:0]  log_resp[64];

    function automatic logic [31:0] data_of(logic [33:0] a);
        if (a == 34'h4) return 32'hDEAD_BEEF;
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [1:0] resp_of(logic [33:0] a);
        return (a == 34'h1000) ? 2'b11 : 2'b00;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT outputs against the model, then advance the model past the next edge.
    task automatic compare_step();
        logic [N-1:0] exp_wr, exp_rdv;
        bit fire, to_fire;
        int idx;
        to_fire = 0;
`ifdef ARMLEOCPU_AVL_ARB_TIMEOUT_EN
        if (m_wait && !avl_readdatavalid && m_cnt == TO - 1) to_fire = 1;
`endif
        fire    = m_wait && (avl_readdatavalid || to_fire);
        exp_wr  = '1;
        exp_rdv = '0;
        if (m_issue) exp_wr[m_owner] = avl_waitrequest;
        if (fire)    exp_rdv[m_owner] = 1'b1;
        chk("avl_read", avl_read, m_issue);
        if (m_issue) chk("avl_address", avl_address, m_addr);
        chk("req_waitrequest", req_waitrequest, exp_wr);
        chk("req_readdatavalid", req_readdatavalid, exp_rdv);
        if (fire) begin
            chk("req_readdata", req_readdata, to_fire ? 32'h0 : avl_readdata);
            chk("req_response", req_response, to_fire ? 2'b11 : avl_response);
            if (log_n < 64) begin
                log_owner[log_n] = m_owner;
                log_data[log_n]  = req_readdata;
                log_resp[log_n]  = req_response;
                log_lat[log_n]   = m_cnt + 1;
            end
            log_n++;
        end
        for (int i = 0; i < N; i++)
            if (req_read[i] && !req_waitrequest[i]) accepted[i]++;
        if (avl_read) rd_cnt++;
        rst_seen = !rst_n;
        acc_seen = rst_n && m_issue && !avl_waitrequest;
        acc_addr = m_addr;
        if (!rst_n) begin
            m_issue = 0; m_wait = 0; m_ptr = 0;
        end else if (m_wait) begin
            if (fire) begin m_wait = 0; m_ptr = (m_owner + 1) % N; end
            else m_cnt++;
        end else if (m_issue) begin
            if (!avl_waitrequest) begin m_issue = 0; m_wait = 1; m_cnt = 0; end
        end else if (|req_read) begin
            idx = -1;
            for (int k = 0; k < N; k++)
                if (idx < 0 && req_read[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
            m_owner = idx;
            m_addr  = req_address[idx*34 +: 34];
            m_issue = 1;
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_read[i]            = (issued[i] != accepted[i]);
            req_address[i*34 +: 34] = raddr[i];
        end
    endtask

    task automatic drive_bus();
        avl_readdatavalid = 1'b0;
        avl_readdata      = $urandom;
        avl_response      = 2'b00;
        if (rst_seen) b_pend = 0;
        else if (acc_seen) begin
            b_pend = !bus_mute; b_lat = bus_lat; b_addr = acc_addr;
        end
        if (b_pend) begin
            if (b_lat <= 1) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = data_of(b_addr);
                avl_response      = resp_of(b_addr);
                b_pend = 0;
            end else b_lat--;
        end
        if (inject_rdv) begin
            avl_readdatavalid = 1'b1;
            avl_readdata      = 32'h1234_5678;
            inject_rdv        = 0;
        end
        if (avl_read) begin
            avl_waitrequest = (b_wcnt < bus_wait);
            b_wcnt++;
        end else begin
            avl_waitrequest = 1'b1;
            b_wcnt = 0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_step();
        @(posedge clk);
        #1;
        drive_bus();
        drive_reqs();
    endtask

    task automatic post(int i, logic [33:0] a);
        raddr[i] = a;
        issued[i]++;
        drive_reqs();
    endtask

    task automatic run_until(int target, int budget, string name);
        int b = budget;
        while (log_n < target && b > 0) begin cyc(); b--; end
        chk(name, log_n, target);
    endtask

    initial begin
        int base, rd0, b;
        for (int i = 0; i < N; i++) begin issued[i] = 0; accepted[i] = 0; raddr[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        chk("reset avl_read", avl_read, 1'b0);
        chk("reset avl_address", avl_address, 34'h0);
        chk("reset req_waitrequest", req_waitrequest, 2'b11);
        chk("reset req_readdatavalid", req_readdatavalid, 2'b00);
        rst_n = 1'b1;

        // single requester
        base = log_n; rd0 = rd_cnt;
        post(0, 34'h4);
        run_until(base + 1, 50, "t1 done");
        repeat (3) cyc();
        chk("t1 owner", log_owner[base], 0);
        chk("t1 data", log_data[base], 32'hDEAD_BEEF);
        chk("t1 resp", log_resp[base], 2'b00);
        chk("t1 avl_read cycles", rd_cnt - rd0, 1);
        chk("t1 count", log_n, base + 1);

        // simultaneous from reset, alternating grants
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        base = log_n;
        post(0, 34'h100); post(0, 34'h100);
        post(1, 34'h200); post(1, 34'h200);
        run_until(base + 4, 100, "t2 done");
        chk("t2 owner0", log_owner[base],     0);
        chk("t2 owner1", log_owner[base + 1], 1);
        chk("t2 owner2", log_owner[base + 2], 0);
        chk("t2 owner3", log_owner[base + 3], 1);
        chk("t2 data0", log_data[base],     32'h5A5A_0100);
        chk("t2 data1", log_data[base + 1], 32'h5A5A_0200);

        // error response to requester 1 only
        base = log_n;
        post(1, 34'h1000);
        run_until(base + 1, 50, "t3 done");
        chk("t3 owner", log_owner[base], 1);
        chk("t3 resp", log_resp[base], 2'b11);

        // 5-cycle bus stall in ISSUE
        base = log_n; bus_wait = 5;
        repeat (2) cyc();
        rd0 = rd_cnt;
        post(0, 34'h2_0000_0008);
        run_until(base + 1, 50, "t4 done");
        repeat (2) cyc();
        chk("t4 avl_read cycles", rd_cnt - rd0, 6);
        chk("t4 data", log_data[base], 32'h5A5A_0008);
        bus_wait = 0;

        // reset during WAIT_DATA, then a late strobe
        base = log_n; bus_mute = 1;
        post(0, 34'h40);
        b = 50;
        while (!m_wait && b > 0) begin cyc(); b--; end
        chk("t5 reached wait", m_wait, 1'b1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1; bus_mute = 0;
        inject_rdv = 1;
        cyc();
        chk("t5 rdv after reset", req_readdatavalid, 2'b00);
        chk("t5 avl_read", avl_read, 1'b0);
        chk("t5 avl_address", avl_address, 34'h0);
        chk("t5 waitrequest", req_waitrequest, 2'b11);
        repeat (2) cyc();
        chk("t5 nothing delivered", log_n, base);
        post(1, 34'h44);
        run_until(base + 1, 50, "t5 recovery");
        chk("t5 owner", log_owner[base], 1);
        chk("t5 data", log_data[base], 32'h5A5A_0044);

`ifdef ARMLEOCPU_AVL_ARB_TIMEOUT_EN
        base = log_n; bus_mute = 1;
        post(0, 34'h80);
        run_until(base + 1, 60, "t6 timeout");
        chk("t6 resp", log_resp[base], 2'b11);
        chk("t6 data", log_data[base], 32'h0);
        chk("t6 wait cycles", log_lat[base], 8);
        cyc(); inject_rdv = 1;
        repeat (3) cyc();
        chk("t6 late dropped", log_n, base + 1);
        bus_mute = 0;
`endif

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
